// File: rtl/r_resp_mux.sv
`default_nettype none
// ============================================================================
//  Module   : r_resp_mux
//  Purpose  : AXI-node R-channel response stage. Routes the beats of the slave
//             granted by the round-robin arbiter into a 2-entry output buffer
//             towards the master port. It drives the per-slave RREADY signals
//             and the burst lock (count_update) that holds the arbiter grant
//             until RLAST has been accepted.
//  Options  : define R_RESP_MUX_PROTO_CHECK_EN to build the sticky protocol
//             checker behind proto_err. Without it, proto_err is tied to 0.
//  Revision : 1.0 - initial release
// ============================================================================
module r_resp_mux #(
  parameter int sID_width  = 6,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            R_SLV_sel,
  input  logic                  ID_valid,
  input  logic [sID_width-1:0]  ID,
  input  logic                  RVALID0,
  input  logic                  RVALID1,
  input  logic                  RVALID2,
  input  logic                  RVALID3,
  input  logic                  RVALID4,
  input  logic [DATA_WIDTH-1:0] RDATA0,
  input  logic [DATA_WIDTH-1:0] RDATA1,
  input  logic [DATA_WIDTH-1:0] RDATA2,
  input  logic [DATA_WIDTH-1:0] RDATA3,
  input  logic [DATA_WIDTH-1:0] RDATA4,
  input  logic [1:0]            RRESP0,
  input  logic [1:0]            RRESP1,
  input  logic [1:0]            RRESP2,
  input  logic [1:0]            RRESP3,
  input  logic [1:0]            RRESP4,
  input  logic                  RLAST0,
  input  logic                  RLAST1,
  input  logic                  RLAST2,
  input  logic                  RLAST3,
  input  logic                  RLAST4,
  output logic                  RREADY0,
  output logic                  RREADY1,
  output logic                  RREADY2,
  output logic                  RREADY3,
  output logic                  RREADY4,
  output logic                  RVALID,
  output logic [DATA_WIDTH-1:0] RDATA,
  output logic [1:0]            RRESP,
  output logic                  RLAST,
  output logic [sID_width-1:0]  RID,
  input  logic                  RREADY,
  output logic                  count_update,
  output logic                  proto_err
);

  typedef enum logic [0:0] {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_t;

  localparam int c_NUM_SLV = 5;

  // Selected-slave view of the R channel
  logic                  w_grant_ok;
  logic                  w_full;
  logic                  w_sel_valid;
  logic [DATA_WIDTH-1:0] w_sel_data;
  logic [1:0]            w_sel_resp;
  logic                  w_sel_last;
  logic [c_NUM_SLV-1:0]  w_rready;
  logic                  w_push;
  logic                  w_pop;

  // Output buffer storage and bookkeeping
  logic                  r_wr_ptr;
  logic                  r_rd_ptr;
  logic [1:0]            r_count;
  logic [sID_width-1:0]  r_id_mem   [2];
  logic [DATA_WIDTH-1:0] r_data_mem [2];
  logic [1:0]            r_resp_mem [2];
  logic                  r_last_mem [2];

  lock_state_t           r_state;
  logic                  r_count_update;

  assign w_grant_ok = ID_valid && (R_SLV_sel <= 3'd4);
  assign w_full     = (r_count == 2'd2);

  // Multiplex the granted slave's R signals; no grant selects an idle slave
  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_data  = '0;
    w_sel_resp  = 2'b00;
    w_sel_last  = 1'b0;
    case (R_SLV_sel)
      3'd0: begin w_sel_valid = RVALID0; w_sel_data = RDATA0; w_sel_resp = RRESP0; w_sel_last = RLAST0; end
      3'd1: begin w_sel_valid = RVALID1; w_sel_data = RDATA1; w_sel_resp = RRESP1; w_sel_last = RLAST1; end
      3'd2: begin w_sel_valid = RVALID2; w_sel_data = RDATA2; w_sel_resp = RRESP2; w_sel_last = RLAST2; end
      3'd3: begin w_sel_valid = RVALID3; w_sel_data = RDATA3; w_sel_resp = RRESP3; w_sel_last = RLAST3; end
      3'd4: begin w_sel_valid = RVALID4; w_sel_data = RDATA4; w_sel_resp = RRESP4; w_sel_last = RLAST4; end
      default: begin
        w_sel_valid = 1'b0;
        w_sel_data  = '0;
        w_sel_resp  = 2'b00;
        w_sel_last  = 1'b0;
      end
    endcase
  end

  // One-hot slave ready; a full buffer blocks acceptance even if it pops this cycle
  generate
    for (genvar gi = 0; gi < c_NUM_SLV; gi++) begin : g_rready
      assign w_rready[gi] = !reset && w_grant_ok && !w_full && (R_SLV_sel == 3'(gi));
    end
  endgenerate

  assign RREADY0 = w_rready[0];
  assign RREADY1 = w_rready[1];
  assign RREADY2 = w_rready[2];
  assign RREADY3 = w_rready[3];
  assign RREADY4 = w_rready[4];

  assign w_push = (|w_rready) && w_sel_valid;
  assign w_pop  = RVALID && RREADY;

  // Master side presents the head entry straight from the storage registers
  assign RVALID = (r_count != 2'd0);
  assign RDATA  = r_data_mem[r_rd_ptr];
  assign RRESP  = r_resp_mem[r_rd_ptr];
  assign RLAST  = r_last_mem[r_rd_ptr];
  assign RID    = r_id_mem[r_rd_ptr];

  // Two-entry buffer: write at wr_ptr on push, advance rd_ptr on pop
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        r_id_mem[i]   <= '0;
        r_data_mem[i] <= '0;
        r_resp_mem[i] <= 2'b00;
        r_last_mem[i] <= 1'b0;
      end
    end else begin
      if (w_push) begin
        r_id_mem[r_wr_ptr]   <= ID;
        r_data_mem[r_wr_ptr] <= w_sel_data;
        r_resp_mem[r_wr_ptr] <= w_sel_resp;
        r_last_mem[r_wr_ptr] <= w_sel_last;
        r_wr_ptr             <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Burst lock follows beats accepted from the slave, not master pops
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= UNLOCKED;
      r_count_update <= 1'b0;
    end else if (w_push) begin
      if (w_sel_last) begin
        r_state        <= UNLOCKED;
        r_count_update <= 1'b0;
      end else begin
        r_state        <= LOCKED;
        r_count_update <= 1'b1;
      end
    end
  end

  assign count_update = r_count_update;

`ifdef R_RESP_MUX_PROTO_CHECK_EN
  logic [7:0]           r_beat_cnt;
  logic [2:0]           r_prev_sel;
  logic [c_NUM_SLV-1:0] r_prev_rvalid;
  logic                 r_prev_push;
  logic                 r_proto_err;
  logic                 w_err_overflow;
  logic                 w_err_sel_change;
  logic                 w_err_valid_drop;

  // A non-last beat beyond 255 means a burst longer than 256 beats
  assign w_err_overflow   = w_push && !w_sel_last && (r_beat_cnt == 8'hFF);
  assign w_err_sel_change = (r_state == LOCKED) && (R_SLV_sel != r_prev_sel);
  // Granted slave withdrew RVALID without having been accepted last cycle
  assign w_err_valid_drop = (|(w_rready & r_prev_rvalid)) && !w_sel_valid && !r_prev_push;

  // Beat counter, history registers and the sticky error flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_beat_cnt    <= 8'd0;
      r_prev_sel    <= 3'd0;
      r_prev_rvalid <= '0;
      r_prev_push   <= 1'b0;
      r_proto_err   <= 1'b0;
    end else begin
      if (w_push) begin
        if (w_sel_last) begin
          r_beat_cnt <= 8'd0;
        end else if (r_beat_cnt != 8'hFF) begin
          r_beat_cnt <= r_beat_cnt + 8'd1;
        end
      end
      r_prev_sel    <= R_SLV_sel;
      r_prev_rvalid <= {RVALID4, RVALID3, RVALID2, RVALID1, RVALID0};
      r_prev_push   <= w_push;
      if (w_err_overflow || w_err_sel_change || w_err_valid_drop) begin
        r_proto_err <= 1'b1;
      end
    end
  end

  assign proto_err = r_proto_err;
`else
  assign proto_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/r_resp_mux.md
Name: r_resp_mux

Overview:
- Read-response stage directly downstream of the AXI-node R-channel round-robin arbiter.
- Takes the arbiter's registered slave select and ID, and routes the selected slave's R beats to the master port through a 2-entry output buffer.
- Drives per-slave RREADY.
- Generates the burst-lock signal `count_update`, which the arbiter uses to hold its grant until RLAST has transferred.

Parameters:
- sID_width, 6, width of RID and of the arbiter ID input.
- DATA_WIDTH, 32, width of RDATA on every port.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- R_SLV_sel  in  3  arbiter grant; 0..4 select slave, 5..7 mean no grant.
- ID_valid  in  1  arbiter registered "some slave RVALID high" flag.
- ID  in  sID_width  arbiter-registered RID of the granted slave.
- RVALID0..RVALID4  in  1 each  slave R valid.
- RDATA0..RDATA4  in  DATA_WIDTH each  slave R data.
- RRESP0..RRESP4  in  2 each  slave R response.
- RLAST0..RLAST4  in  1 each  slave R last.
- RREADY0..RREADY4  out  1 each  slave R ready (combinational).
- RVALID  out  1  master R valid.
- RDATA  out  DATA_WIDTH  master R data.
- RRESP  out  2  master R response.
- RLAST  out  1  master R last.
- RID  out  sID_width  master R ID.
- RREADY  in  1  master R ready.
- count_update  out  1  burst-in-progress lock to the arbiter.
- proto_err  out  1  sticky protocol error (see Optional Feature).

Behaviour:
- Reset (async, active-high):
  - FIFO cleared: rd_ptr = wr_ptr = 0, count = 0.
  - Outputs: RVALID = 0, RDATA = 0, RRESP = 0, RLAST = 0, RID = 0, count_update = 0, proto_err = 0.
  - All RREADYx = 0 while reset is asserted.
  - Reset mid-burst discards buffered beats and releases the lock.
- grant_ok = ID_valid && (R_SLV_sel <= 4).
- RREADYx = grant_ok && (R_SLV_sel == x) && (count != 2). Combinational; at most one RREADYx is high per cycle.
- push = RREADY[sel] && RVALID[sel]. On push, write {ID, RDATAsel, RRESPsel, RLASTsel} into FIFO entry wr_ptr.
- pop = RVALID && RREADY.
- FIFO:
  - 2 entries; 1-bit pointers that wrap 1 -> 0.
  - count is 2 bits: +1 on push only, -1 on pop only, unchanged on push and pop together.
  - When count == 2, push is blocked even if a pop occurs in the same cycle (no pass-through on full).
  - Pop on empty cannot occur, because RVALID = (count != 0).
- Master outputs RDATA/RRESP/RLAST/RID are the head entry (rd_ptr), driven from registers.
- Latency: a beat pushed in cycle N is visible on RVALID in cycle N+1 when the FIFO was empty.
- RVALID/RDATA/RRESP/RLAST/RID are held stable while RVALID && !RREADY.
- count_update (registered) state machine, states UNLOCKED and LOCKED:
  - UNLOCKED -> LOCKED on push with RLAST = 0.
  - LOCKED -> UNLOCKED on push with RLAST = 1.
  - A single-beat burst (RLAST = 1 on the first beat) stays UNLOCKED.
  - count_update = (state == LOCKED).
  - The lock tracks beats accepted from slaves, not master pops.
- Grant change while LOCKED is not expected. If it happens, beats from the new slave are accepted normally and the lock continues to follow RLAST.

Optional Feature:
- Macro: R_RESP_MUX_PROTO_CHECK_EN.
- Defined:
  - An 8-bit beat counter increments on each non-last push and clears on a last push.
  - proto_err sets and stays set until reset when any of these occurs:
    - a push would take the counter past 255 (burst longer than 256 beats);
    - R_SLV_sel changes while LOCKED;
    - RVALID[sel] is low in a cycle where RREADY[sel] was high and RVALID[sel] was high the previous cycle, with no push in that previous cycle (valid dropped without handshake).
- Not defined: proto_err tied to 0; no counter logic is generated.

Test Plan:
- Single beat: sel = 2, ID_valid = 1, ID = 6'h15, RVALID2 = 1, RDATA2 = 32'hA5A5_0001, RLAST2 = 1, RREADY = 1 -> RREADY2 high in cycle N; in N+1 RVALID = 1, RDATA = A5A5_0001, RID = 6'h15, RLAST = 1; count_update stays 0.
- 4-beat burst from slave 0 with master RREADY = 1 -> count_update = 1 from the cycle after beat 1 through the cycle of beat 4's push, returns to 0 the cycle after; 4 beats exit in order.
- Backpressure: RREADY = 0, slave 1 streams 3 beats -> RREADY1 drops after 2 pushes (count = 2); RDATA holds beat 1; raising RREADY pops beat 1, and beat 3 is accepted the cycle after the pop.
- No grant: R_SLV_sel = 5, or ID_valid = 0 while RVALID3 = 1 -> all RREADYx = 0; RVALID stays 0.
- Reset mid-burst: assert reset after beat 2 of 4 with the FIFO holding 1 entry -> RVALID = 0, count_update = 0 immediately; after release, a new single-beat transfer behaves as in the single-beat scenario.
- With R_RESP_MUX_PROTO_CHECK_EN: change sel 0 -> 3 while LOCKED -> proto_err = 1 next cycle and stays 1 until reset.
